// File: rtl/rs_stream_encoder_if.sv
// Symbol stream bundle for the RS encoder: message input, codeword output and status.
interface rs_stream_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sym;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sym;
  logic       out_sof;
  logic       out_eof;
  logic       busy;

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_sym, out_sof, out_eof, busy
  );

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_sym, out_sof, out_eof, busy
  );
endinterface

// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder over GF(16): message symbols pass through,
// then NSYM parity symbols are shifted out of the division LFSR.
module rs_stream_encoder #(
  parameter int K    = 9,
  parameter int NSYM = 6
) (
  input logic          clk,
  input logic          rst_n,
  rs_stream_encoder_if.slave bus
);

  localparam int MAXC = (K > NSYM) ? K : NSYM;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] MSG_LAST = CW'(K - 1);
  localparam logic [CW-1:0] PAR_LAST = CW'(NSYM - 1);

  generate
    if (K < 1 || NSYM < 2 || (NSYM % 2) != 0 || (K + NSYM) > 15) begin : g_param_check
      $error("rs_stream_encoder: illegal K/NSYM combination");
    end
  endgenerate

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    end
    return p;
  endfunction

  // Expands prod (x + alpha^i) and keeps the non-leading coefficients g0..g(NSYM-1).
  function automatic logic [4*NSYM-1:0] gen_poly();
    logic [3:0]        g [16];
    logic [3:0]        root;
    logic [4*NSYM-1:0] packed_g;
    for (int j = 0; j < 16; j++) g[j] = 4'h0;
    g[0] = 4'h1;
    root = 4'h1;
    for (int i = 1; i <= NSYM; i++) begin
      root = gf_mul(root, 4'h2);
      for (int j = i; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(root, g[j]);
      g[0] = gf_mul(root, g[0]);
    end
    packed_g = '0;
    for (int j = 0; j < NSYM; j++) packed_g[4*j +: 4] = g[j];
    return packed_g;
  endfunction

  localparam logic [4*NSYM-1:0] GEN = gen_poly();

  typedef enum logic {MSG, PAR} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      lfsr_reg  [NSYM];
  logic [3:0]      lfsr_next [NSYM];
  logic [3:0]      out_sym_reg, out_sym_next;
  logic            out_valid_reg, out_valid_next;
  logic            out_sof_reg, out_sof_next;
  logic            out_eof_reg, out_eof_next;
  logic            adv;
  logic            accept;
  logic [3:0]      fb;
  logic [3:0]      fb_prod [NSYM];

  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = rst_n && (state_reg == MSG) && adv;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fb           = bus.in_sym ^ lfsr_reg[NSYM-1];

  assign bus.out_sym   = out_sym_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sof   = out_sof_reg;
  assign bus.out_eof   = out_eof_reg;
  assign bus.busy      = (state_reg == PAR) || (cnt_reg != '0) || out_valid_reg;

  generate
    for (genvar gi = 0; gi < NSYM; gi++) begin : g_lfsr
      assign fb_prod[gi] = gf_mul(fb, GEN[4*gi +: 4]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_reg[gi] <= '0;
        else        lfsr_reg[gi] <= lfsr_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= MSG;
      cnt_reg       <= '0;
      out_sym_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      out_sym_reg   <= out_sym_next;
      out_valid_reg <= out_valid_next;
      out_sof_reg   <= out_sof_next;
      out_eof_reg   <= out_eof_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lfsr_next      = lfsr_reg;
    out_sym_next   = out_sym_reg;
    out_valid_next = out_valid_reg;
    out_sof_next   = out_sof_reg;
    out_eof_next   = out_eof_reg;

    if (state_reg == MSG) begin
      if (accept) begin
        out_sym_next   = bus.in_sym;
        out_valid_next = 1'b1;
        out_sof_next   = (cnt_reg == '0);
        out_eof_next   = 1'b0;
        lfsr_next[0]   = fb_prod[0];
        for (int i = 1; i < NSYM; i++) lfsr_next[i] = lfsr_reg[i-1] ^ fb_prod[i];
        if (cnt_reg == MSG_LAST) begin
          state_next = PAR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end else if (adv) begin
        out_valid_next = 1'b0;
      end
    end else if (adv) begin
      out_sym_next   = lfsr_reg[NSYM-1];
      out_valid_next = 1'b1;
      out_sof_next   = 1'b0;
      out_eof_next   = (cnt_reg == PAR_LAST);
      lfsr_next[0]   = '0;
      for (int i = 1; i < NSYM; i++) lfsr_next[i] = lfsr_reg[i-1];
      if (cnt_reg == PAR_LAST) begin
        // Last parity symbol leaves: start the next codeword from a clean divider.
        for (int i = 0; i < NSYM; i++) lfsr_next[i] = '0;
        cnt_next   = '0;
        state_next = MSG;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Randomised self-checking bench for rs_stream_encoder against a polynomial-division
// reference model; covers RS(15,9), RS(15,11) and RS(3,1) instances.
module tb_rs_stream_encoder;

  typedef logic [3:0] sym_arr_t [15];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  rs_stream_encoder_if ifa();
  rs_stream_encoder_if ifb();
  rs_stream_encoder_if ifc();

  rs_stream_encoder #(.K(9),  .NSYM(6)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  rs_stream_encoder #(.K(11), .NSYM(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  rs_stream_encoder #(.K(1),  .NSYM(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: GF(16) log tables + long division ----------------
  logic [3:0] exp_tab [15];
  int         log_tab [16];

  function automatic void gf_init();
    logic [3:0] v;
    v = 4'h1;
    for (int i = 0; i < 15; i++) begin
      exp_tab[i] = v;
      log_tab[v] = i;
      v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
    end
  endfunction

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 0 || b == 0) return 4'h0;
    return exp_tab[(log_tab[a] + log_tab[b]) % 15];
  endfunction

  // s holds the message in send order (s[0] = m[K-1]); c is the codeword in output order.
  function automatic void ref_encode(input int k, input int nsym, input sym_arr_t s, output sym_arr_t c);
    logic [3:0] g [16];
    logic [3:0] p [16];
    logic [3:0] q;
    int         n;
    n = k + nsym;
    for (int j = 0; j < 16; j++) begin
      g[j] = 4'h0;
      p[j] = 4'h0;
    end
    g[0] = 4'h1;
    for (int i = 1; i <= nsym; i++)
      for (int j = i; j >= 0; j--)
        g[j] = ((j > 0) ? g[j-1] : 4'h0) ^ gmul(exp_tab[i % 15], g[j]);
    for (int j = 0; j < k; j++) p[n-1-j] = s[j];
    for (int d = n - 1; d >= nsym; d--) begin
      q = p[d];
      for (int j = 0; j <= nsym; j++) p[d-nsym+j] = p[d-nsym+j] ^ gmul(q, g[j]);
    end
    for (int j = 0; j < 15; j++) c[j] = 4'h0;
    for (int j = 0; j < n; j++) c[j] = (j < k) ? s[j] : p[n-1-j];
  endfunction

  function automatic sym_arr_t rand_msg(input int k);
    sym_arr_t s;
    for (int j = 0; j < 15; j++) s[j] = (j < k) ? 4'($urandom_range(0, 15)) : 4'h0;
    return s;
  endfunction

  // ---------------- DUT A: scoreboard, stall checker, throughput window ----------------
  logic [5:0] exp_q [$];
  logic       rand_ready = 1'b0;
  logic       gaps = 1'b0;
  logic       win = 1'b0;
  int         beat_cnt = 0;
  int         first_beat = -1;
  int         last_beat = -1;
  logic       held_v = 1'b0;
  logic [5:0] held_out;
  logic [5:0] exp_item;

  always @(posedge clk) begin
    #1;
    ifa.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid", ifa.out_valid, 1);
        check("stall_out", {ifa.out_sof, ifa.out_eof, ifa.out_sym}, held_out);
      end
      if (ifa.out_valid && ifa.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          exp_item = exp_q.pop_front();
          check("a_sym", ifa.out_sym, exp_item[3:0]);
          check("a_sof", ifa.out_sof, exp_item[5]);
          check("a_eof", ifa.out_eof, exp_item[4]);
        end
        if (win) begin
          if (first_beat < 0) first_beat = cyc;
          last_beat = cyc;
          beat_cnt++;
        end
      end
      held_v   = ifa.out_valid && !ifa.out_ready;
      held_out = {ifa.out_sof, ifa.out_eof, ifa.out_sym};
    end
  end

  task automatic push_exp(input sym_arr_t c, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back({(j == 0), (j == n - 1), c[j]});
  endtask

  task automatic send_sym_a(input logic [3:0] s);
    int t;
    if (gaps && $urandom_range(0, 3) == 0) begin
      ifa.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    ifa.in_valid = 1'b1;
    ifa.in_sym   = s;
    t = 0;
    @(negedge clk);
    while (!ifa.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("a_accept_timeout", t, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_cw_a(input sym_arr_t s);
    for (int j = 0; j < 9; j++) send_sym_a(s[j]);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || ifa.busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT B / C: capture and post-check ----------------
  logic [5:0] got_b [$];
  logic [5:0] got_c [$];
  logic [3:0] msg_b [$];
  logic [3:0] msg_c [$];

  always @(negedge clk)
    if (rst_n && ifb.out_valid && ifb.out_ready) got_b.push_back({ifb.out_sof, ifb.out_eof, ifb.out_sym});
  always @(negedge clk)
    if (rst_n && ifc.out_valid && ifc.out_ready) got_c.push_back({ifc.out_sof, ifc.out_eof, ifc.out_sym});

  task automatic check_alt(input string tag, input int k, input int nsym, input int ncw,
                           input logic [3:0] msgs [$], input logic [5:0] got [$]);
    sym_arr_t   s;
    sym_arr_t   c;
    logic [3:0] acc;
    int         n;
    int         idx;
    n = k + nsym;
    check({tag, "_count"}, got.size(), ncw * n);
    for (int w = 0; w < ncw; w++) begin
      for (int j = 0; j < 15; j++) s[j] = (j < k) ? msgs[w*k + j] : 4'h0;
      ref_encode(k, nsym, s, c);
      for (int j = 0; j < n; j++) begin
        idx = w * n + j;
        if (idx < got.size()) begin
          check({tag, "_sym"}, got[idx][3:0], c[j]);
          check({tag, "_sof"}, got[idx][5], (j == 0));
          check({tag, "_eof"}, got[idx][4], (j == n - 1));
        end
      end
      for (int i = 1; i <= nsym; i++) begin
        acc = 4'h0;
        for (int j = 0; j < n; j++) begin
          idx = w * n + j;
          acc = gmul(acc, exp_tab[i]) ^ ((idx < got.size()) ? got[idx][3:0] : 4'hF);
        end
        check({tag, "_syndrome"}, acc, 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  sym_arr_t zero_msg;
  sym_arr_t unit_msg;
  sym_arr_t unit_exp;
  sym_arr_t s_tmp;
  sym_arr_t c_tmp;
  int       t_b;
  int       t_c;

  initial begin
    gf_init();
    zero_msg = '{default: 4'h0};
    unit_msg = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    unit_exp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC};
    ifa.in_valid = 1'b0; ifa.in_sym = 4'h0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_sym = 4'h0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_sym = 4'h0; ifc.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_out_sym", ifa.out_sym, 0);
    check("rst_in_ready", ifa.in_ready, 0);
    check("rst_busy", ifa.busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", ifa.in_ready, 1);
    @(posedge clk);
    #1;

    // zero message
    push_exp(zero_msg, 15);
    send_cw_a(zero_msg);
    ifa.in_valid = 1'b0;
    wait_drain();

    // unit message against the known RS(15,9) parity
    push_exp(unit_exp, 15);
    send_cw_a(unit_msg);
    ifa.in_valid = 1'b0;
    wait_drain();

    // backpressure and input gaps
    rand_ready = 1'b1;
    gaps = 1'b1;
    push_exp(unit_exp, 15);
    send_cw_a(unit_msg);
    for (int w = 0; w < 6; w++) begin
      s_tmp = rand_msg(9);
      ref_encode(9, 6, s_tmp, c_tmp);
      push_exp(c_tmp, 15);
      send_cw_a(s_tmp);
    end
    ifa.in_valid = 1'b0;
    wait_drain();
    rand_ready = 1'b0;
    gaps = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back random codewords at full rate
    win = 1'b1;
    beat_cnt = 0;
    first_beat = -1;
    for (int w = 0; w < 100; w++) begin
      s_tmp = rand_msg(9);
      ref_encode(9, 6, s_tmp, c_tmp);
      push_exp(c_tmp, 15);
      send_cw_a(s_tmp);
    end
    ifa.in_valid = 1'b0;
    wait_drain();
    win = 1'b0;
    check("b2b_beats", beat_cnt, 1500);
    check("b2b_span", last_beat - first_beat, 1499);

    // reset in the middle of a codeword
    s_tmp = rand_msg(9);
    ref_encode(9, 6, s_tmp, c_tmp);
    push_exp(c_tmp, 15);
    for (int j = 0; j < 4; j++) send_sym_a(s_tmp[j]);
    #2;
    rst_n = 1'b0;
    ifa.in_valid = 1'b0;
    #1;
    check("midrst_out_valid", ifa.out_valid, 0);
    check("midrst_out_sym", ifa.out_sym, 0);
    check("midrst_out_sof", ifa.out_sof, 0);
    check("midrst_in_ready", ifa.in_ready, 0);
    check("midrst_busy", ifa.busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(unit_exp, 15);
    send_cw_a(unit_msg);
    ifa.in_valid = 1'b0;
    wait_drain();

    // alternate parameter sets running in parallel
    fork
      begin
        for (int w = 0; w < 20; w++) begin
          s_tmp = rand_msg(11);
          for (int j = 0; j < 11; j++) begin
            msg_b.push_back(s_tmp[j]);
            ifb.in_valid = 1'b1;
            ifb.in_sym   = s_tmp[j];
            t_b = 0;
            @(negedge clk);
            while (!ifb.in_ready && t_b < 100) begin
              @(negedge clk);
              t_b++;
            end
            if (t_b >= 100) check("b_accept_timeout", t_b, 0);
            @(posedge clk);
            #1;
          end
        end
        ifb.in_valid = 1'b0;
      end
      begin
        for (int w = 0; w < 20; w++) begin
          logic [3:0] sc;
          sc = 4'($urandom_range(0, 15));
          msg_c.push_back(sc);
          ifc.in_valid = 1'b1;
          ifc.in_sym   = sc;
          t_c = 0;
          @(negedge clk);
          while (!ifc.in_ready && t_c < 100) begin
            @(negedge clk);
            t_c++;
          end
          if (t_c >= 100) check("c_accept_timeout", t_c, 0);
          @(posedge clk);
          #1;
        end
        ifc.in_valid = 1'b0;
      end
    join
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_alt("k11", 11, 4, 20, msg_b, got_b);
    check_alt("k1", 1, 2, 20, msg_c, got_c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_stream_encoder.md
Name: rs_stream_encoder

Overview:
- Streaming, parametrised systematic Reed-Solomon encoder over GF(16).
- Successor to the one-shot fixed RS(15,9) packed-vector encoder. It accepts one 4-bit message symbol per handshake, passes each message symbol straight through, then emits NSYM parity symbols.
- Sits between the symbol source and the channel/modulator.
- Backpressure supported on both sides; back-to-back codewords run with no bubble.

Parameters:
- K, 9, message symbols per codeword. Must satisfy K ≥ 1.
- NSYM, 6, parity symbols per codeword. Must be even, NSYM ≥ 2, and K+NSYM ≤ 15.
- Any illegal K/NSYM combination is an elaboration-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_sym is valid.
- in_ready  output  1  encoder can accept in_sym this cycle.
- in_sym  input  4  message symbol. Highest-degree symbol (m[K-1]) comes first.
- out_valid  output  1  out_sym is valid.
- out_ready  input  1  downstream accepts out_sym.
- out_sym  output  4  codeword symbol. Order is c[N-1] down to c[0], where N = K+NSYM.
- out_sof  output  1  qualifies the first symbol of a codeword.
- out_eof  output  1  qualifies the last parity symbol of a codeword.
- busy  output  1  high while a codeword is partially accepted or emitted.

Behaviour:
- Field: GF(16), primitive polynomial x^4+x+1, bit0 = LSB, alpha = 4'b0010, alpha^4 = 4'b0011.
- Generator polynomial: g(x) = prod_{i=1..NSYM}(x+alpha^i).
  - Coefficients g0..g(NSYM-1) are computed at elaboration by a constant function.
  - No runtime tables.
  - For NSYM=6: g = x^6 + a^10 x^5 + a^14 x^4 + a^4 x^3 + a^6 x^2 + a^9 x + a^6.
- Codeword: c(x) = x^NSYM·m(x) + (x^NSYM·m(x) mod g(x)).
  - For K=9, NSYM=6 the result is bit-identical to the legacy packed encoder, with out symbol j equal to codeword[14-j].
- Registered output stage: out_sym, out_valid, out_sof, out_eof are flops.
- Define adv = !out_valid || out_ready. The output register is loaded only when adv is high.
- State machine: MSG and PAR; counter cnt, wide enough for max(K, NSYM).
- MSG:
  - in_ready = adv.
  - On accept (in_valid && in_ready):
    - out_sym <= in_sym, out_valid <= 1.
    - out_sof <= (cnt==0), out_eof <= 0.
    - fb = in_sym ^ lfsr[NSYM-1]; lfsr[0] <= fb·g0; lfsr[i] <= lfsr[i-1] ^ fb·gi.
    - cnt++.
  - When cnt==K-1 on accept: go to PAR and clear cnt.
- PAR:
  - in_ready = 0.
  - When adv: out_sym <= lfsr[NSYM-1], lfsr shifts up with lfsr[0] <= 0, out_valid <= 1, out_sof <= 0, cnt++.
  - out_eof <= (cnt==NSYM-1).
  - On the last parity load: lfsr is cleared to 0, cnt <= 0, go to MSG.
- Output drain: when adv is high and no new load occurs, out_valid <= 0.
- Latency and throughput:
  - Input-to-output latency is 1 cycle.
  - With in_valid and out_ready held high, codewords stream at N cycles each with no idle cycle between codewords.
- K==1 edge case: the first accept transitions directly to PAR. out_sof and the message symbol coincide.
- busy = (state==PAR) || (cnt!=0) || out_valid.
- Stall rules:
  - out_ready low holds out_sym, out_valid, out_sof, out_eof stable.
  - lfsr and cnt do not advance while stalled.
  - in_valid low in MSG inserts bubbles on the output but does not corrupt state.
- Reset (asynchronous assert, any cycle including mid-codeword):
  - state <= MSG, cnt <= 0, lfsr <= 0.
  - out_valid, out_sof, out_eof, out_sym <= 0.
  - in_ready goes low during reset.
  - A partial codeword is discarded. The next accepted symbol after reset is treated as m[K-1].
- Multiply: combinational GF(16) multiply, polynomial basis, reduction by x^4+x+1.

Test Plan:
- Zero message (K=9, NSYM=6): 9×0x0 in, out_ready=1 → 15×0x0 out. out_sof on symbol 0, out_eof on symbol 14, each codeword 15 cycles.
- Unit message (K=9, NSYM=6): m = 0,0,0,0,0,0,0,0,1 → out 0×8, 0x1, then parity 0x7, 0x9, 0x3, 0xC, 0xA, 0xC.
- Backpressure: same unit message with out_ready toggled pseudo-randomly → identical sequence, no drops or duplicates, outputs stable while out_ready=0.
- Back-to-back: 100 random codewords with in_valid=out_ready=1 → 1500 symbols in 1500 cycles plus 1 latency cycle; all match the reference model (K=9, NSYM=6).
- Reset mid-codeword: assert rst_n=0 after 4 message symbols, then send the unit message → outputs 0 immediately on reset; the post-reset codeword equals the unit-message result.
- Alternate parameters (K=11, NSYM=4; also K=1, NSYM=2): random messages → every codeword c(alpha^i)=0 for i=1..NSYM. For K=1, out_sof and the message symbol occur in the same beat.
